// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
// ------------
// UART transmit controller. It accepts one parallel word over a valid/ready
// handshake, enables the shared baud-rate tick generator, and shifts out one
// serial frame. The frame is start bit, data bits LSB first, an optional
// parity bit, and then one or two stop bits. The frame advances one bit per
// baud tick.
//
// Handshake semantics: a transfer happens on any rising clk edge where
// tx_valid && tx_ready. tx_ready is high only in IDLE. tx_data is sampled on
// that edge only. The host may hold tx_valid high, and the next word is then
// taken on the first IDLE cycle after the current frame.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-low reset
//   tx_data     word to transmit (DATA_BITS wide)
//   tx_valid    tx_data is valid
//   tx_ready    controller can accept a word (IDLE)
//   baud_tick   one-clk pulse per bit period from the baud generator
//   baud_en     enables the baud generator; low restarts its phase
//   txd         serial line, idle high
//   tx_busy     a frame is in progress
//   frame_done  one-clk pulse after the last stop bit completes
//   state_dbg   current FSM state encoding (debug/observability)

module uart_tx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 frame_done,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       ODD_FLIP  = (PARITY_ODD != 0);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic                 done_q, done_d;
  logic                 tick;

  // The generator is only enabled outside IDLE. A tick that arrives while it
  // is disabled, including on the handshake cycle, is therefore ignored.
  assign tick = baud_tick && baud_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ ODD_FLIP;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (cnt_q == LAST_STOP) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // txd is decoded from registered state only. An asynchronous reset
  // therefore drives the line high at once.
  always_comb begin
    txd = 1'b1;
    case (state_q)
      S_START:  txd = 1'b0;
      S_DATA:   txd = shift_q[0];
      S_PARITY: txd = par_q;
      default:  txd = 1'b1;
    endcase
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign baud_en    = (state_q != S_IDLE);
  assign tx_busy    = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- UART transmit controller that sequences the shared baud-rate tick generator into serial frames.
- Accepts one parallel byte over a valid/ready handshake and enables the baud generator.
- Shifts out start, data (LSB first), optional parity and stop bits, advancing one bit per baud tick.
- Sits between the UART host-side logic and the baud-rate clock generator's TX tick output.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock (100 MHz nominal).
- rst  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_BITS  byte to transmit; sampled only on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  controller can accept a byte.
- baud_tick  input  1  one-clk pulse per bit period from the baud generator (TX tick).
- baud_en  output  1  enables the baud generator; low restarts its phase.
- txd  output  1  serial line, idle high.
- tx_busy  output  1  a frame is in progress.
- frame_done  output  1  one-clk pulse when the last stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - State forced to IDLE.
  - txd=1, tx_ready=1 after release, tx_busy=0, baud_en=0, frame_done=0.
  - Bit counter and shift register are cleared.
- States and transitions:
  - IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- IDLE:
  - txd=1, tx_ready=1, baud_en=0, tx_busy=0.
  - baud_tick is ignored.
  - Handshake occurs when tx_valid && tx_ready on a rising clk edge.
  - On handshake: latch tx_data into the shift register, compute the parity bit, go to START.
  - On the next cycle: txd=0, tx_ready=0, tx_busy=1, baud_en=1.
- Bit timing:
  - Each bit holds txd constant until a cycle with baud_tick=1 while baud_en is high.
  - On that tick the next state/bit drives txd on the following clk edge.
  - The generator restarts phase when baud_en rises, so the first tick arrives one bit period after START begins.
- START: on tick -> DATA; txd = shift[0]; bit counter = 0.
- DATA:
  - On tick: shift right and increment the counter.
  - After DATA_BITS ticks: go to PARITY if PARITY_EN, else STOP.
- Parity bit: XOR of the latched data, inverted when PARITY_ODD=1.
- PARITY: txd = parity bit; on tick -> STOP.
- STOP:
  - txd=1 for STOP_BITS ticks.
  - On the final tick: frame_done=1 for exactly one clk, next state IDLE, baud_en drops.
- Back-to-back frames:
  - tx_ready reasserts the cycle after the final stop tick.
  - Minimum inter-frame gap is 1 clk of idle-high on txd (stop bit effectively extended by 1 clk).
- Other boundary conditions:
  - tx_data/tx_valid changes while busy are ignored.
  - tx_valid held high through a frame is accepted again in IDLE.
  - A baud_tick coincident with the handshake cycle is ignored (baud_en still 0).
  - Reset mid-frame: txd returns high immediately (async); the partial frame is discarded and no frame_done pulse is generated.
- Frame length in ticks: 1 + DATA_BITS + PARITY_EN + STOP_BITS.

Test Plan:
- Defaults, 0xA5, tick every 868 clk:
  - Required txd bits per tick interval: 0,1,0,1,0,0,1,0,1,1.
  - frame_done pulses once, 10×868 clk (±1) after handshake.
- PARITY_EN=1, PARITY_ODD=0, 0xA5: parity bit = 0. With PARITY_ODD=1: parity bit = 1. Frame is 11 bit periods.
- STOP_BITS=2, 0x00: txd low for 9 bit periods, then high for 2; tx_ready stays low until the final stop tick +1 clk.
- tx_valid held high with 0x3C then 0xC3: two frames, exactly one idle clk between them, each byte sent once, and data changed mid-frame has no effect.
- rst pulled low during DATA bit 3:
  - txd=1 and baud_en=0 immediately; no frame_done.
  - After release, a new 0x55 frame is transmitted correctly.
- baud_tick pulses in IDLE and on the handshake cycle: no state change; the START bit lasts a full tick interval.
